mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl_if.sv | 14 +
 rtl/mux_scan_ctrl.sv | 72 +++++++
 tb/tb_mux_scan_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: request, mux-select and scan-result signals of the scan controller
interface mux_scan_ctrl_if;
  logic start;
  logic cont;
  logic y;
  logic s0;
  logic s1;
  logic s2;
  logic busy;
  logic done;
  logic [7:0] data_out;
  modport master (output start, cont, y, input s0, s1, s2, busy, done, data_out);
  modport slave (input start, cont, y, output s0, s1, s2, busy, done, data_out);
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks an 8:1 mux select 0..7, lets each value settle, samples y into an 8-bit word
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic clk,
  input logic rst_n,
  mux_scan_ctrl_if.slave m
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  // With no settle time every select value gets a single cycle, spent entirely in SAMPLE
  localparam state_t ENTRY = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_q, data_n;
  logic done_q, done_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      data_q <= data_n;
      done_q <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    data_n = data_q;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (m.start) begin
          state_n = ENTRY;
          cnt_n = '0;
        end
      end
      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt_n == 4'(SETTLE_CYC)) state_n = SAMPLE;
      end
      SAMPLE: begin
        sh_n[idx] = m.y;
        cnt_n = '0;
        idx_n = idx + 3'd1;
        state_n = ENTRY;
        if (idx == 3'd7) begin
          data_n = sh_n;
          done_n = 1'b1;
          state_n = m.cont ? ENTRY : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign m.s0 = idx[2];
  assign m.s1 = idx[1];
  assign m.s2 = idx[0];
  assign m.busy = state != IDLE;
  assign m.done = done_q;
  assign m.data_out = data_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two controllers (settle 2 and settle 0) against a cycle-count reference model
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] st = '0;
  logic [1:0] ct = '0;
  logic [7:0] dp [2];
  int n_tests = 0;
  int n_fail = 0;
  int d0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : ln
    localparam int W = (g == 0 ? 2 : 0) + 1;
    mux_scan_ctrl_if bus ();
    mux_scan_ctrl #(.SETTLE_CYC(W - 1)) dut (.clk(clk), .rst_n(rst_n), .m(bus.slave));
    logic nz = 1'b0;
    logic act = 1'b0;
    logic xdone = 1'b0;
    logic [7:0] cap = '0;
    logic [7:0] xdata = '0;
    int k = 0;
    int dones = 0;
    assign bus.start = st[g];
    assign bus.cont = ct[g];
    assign bus.y = dp[g][{bus.s0, bus.s1, bus.s2}] ^ nz;
    // k counts cycles into the current scan; select value k/W, sampled on its last cycle
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        act = 1'b0;
        k = 0;
        cap = '0;
        xdata = '0;
        xdone = 1'b0;
      end else begin
        xdone = 1'b0;
        if (act) begin
          if ((k + 1) % W == 0) cap[k / W] = dp[g][k / W];
          k++;
          if (k == 8 * W) begin
            xdata = cap;
            xdone = 1'b1;
            k = 0;
            act = ct[g];
          end
        end else if (st[g]) begin
          act = 1'b1;
          k = 0;
        end
      end
    always @(negedge clk)
      if (rst_n) begin
        check($sformatf("lane%0d sel", g), 32'({bus.s0, bus.s1, bus.s2}), act ? k / W : 0);
        check($sformatf("lane%0d busy", g), 32'(bus.busy), 32'(act));
        check($sformatf("lane%0d done", g), 32'(bus.done), 32'(xdone));
        check($sformatf("lane%0d data_out", g), 32'(bus.data_out), 32'(xdata));
        if (bus.done) dones++;
        nz = (!act || (k + 1) % W != 0) ? 1'($urandom) : 1'b0;
      end
  end
  task automatic pulse(input logic [1:0] mask);
    @(negedge clk);
    st = mask;
    @(negedge clk);
    st = '0;
  endtask
  initial begin
    rst_n = 1'b0;
    dp[0] = 8'h96;
    dp[1] = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset data0", 32'(ln[0].bus.data_out), 0);
    check("reset busy0", 32'(ln[0].bus.busy), 0);
    check("reset sel1", 32'({ln[1].bus.s0, ln[1].bus.s1, ln[1].bus.s2}), 0);
    rst_n = 1'b1;
    pulse(2'b11);
    repeat (9) @(negedge clk);
    st = 2'b01;
    @(negedge clk);
    st = '0;
    repeat (20) @(negedge clk);
    check("scan96 data", 32'(ln[0].bus.data_out), 32'h96);
    check("scan96 dones", ln[0].dones, 1);
    check("scanFF data", 32'(ln[1].bus.data_out), 32'hFF);
    check("scanFF dones", ln[1].dones, 1);
    ct[0] = 1'b1;
    pulse(2'b01);
    repeat (30) @(negedge clk);
    dp[0] = 8'h00;
    repeat (5) @(negedge clk);
    ct[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("cont data", 32'(ln[0].bus.data_out), 32'h02);
    check("cont dones", ln[0].dones, 3);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        st[g] = $urandom_range(0, 9) == 0;
        if ($urandom_range(0, 15) == 0) ct[g] = 1'($urandom);
        if ($urandom_range(0, 7) == 0) dp[g] = 8'($urandom);
      end
    end
    st = '0;
    ct = '0;
    repeat (60) @(negedge clk);
    dp[0] = 8'h96;
    pulse(2'b01);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort sel", 32'({ln[0].bus.s0, ln[0].bus.s1, ln[0].bus.s2}), 0);
    check("abort busy", 32'(ln[0].bus.busy), 0);
    check("abort done", 32'(ln[0].bus.done), 0);
    check("abort data0", 32'(ln[0].bus.data_out), 0);
    check("abort data1", 32'(ln[1].bus.data_out), 0);
    d0 = ln[0].dones;
    #1 rst_n = 1'b1;
    pulse(2'b01);
    repeat (30) @(negedge clk);
    check("restart data", 32'(ln[0].bus.data_out), 32'h96);
    check("restart dones", ln[0].dones, d0 + 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
